// File: rtl/data_sram_ctrl_pkg.sv
// Shared constants for the MEM-stage data SRAM controller: default timing,
// FSM state encodings and the byte-lane helper.
package data_sram_ctrl_pkg;

  localparam int SRAM_AW_DEF    = 20;
  localparam int READ_WAIT_DEF  = 2;
  localparam int WRITE_WAIT_DEF = 2;

  localparam logic [2:0] DRAM_IDLE    = 3'd0;
  localparam logic [2:0] DRAM_READ    = 3'd1;
  localparam logic [2:0] DRAM_WRITE   = 3'd2;
  localparam logic [2:0] DRAM_WR_HOLD = 3'd3;
  localparam logic [2:0] DRAM_DONE    = 3'd4;

  // MEM lane order matches the SRAM byte pins one-to-one, so only inversion is needed.
  function automatic logic [3:0] be_n_from_select(input logic [3:0] sel);
    return ~sel;
  endfunction

endpackage

// File: rtl/data_sram_ctrl.sv
// Turns single MEM-stage data-RAM requests into multi-cycle async SRAM
// accesses, stalling the pipeline until the access completes.
module data_sram_ctrl
  import data_sram_ctrl_pkg::*;
#(
  parameter int SRAM_AW    = SRAM_AW_DEF,
  parameter int READ_WAIT  = READ_WAIT_DEF,
  parameter int WRITE_WAIT = WRITE_WAIT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ram_en_i,
  input  logic               mem_write_en_i,
  input  logic [3:0]         mem_select_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        store_data_i,
  output logic [31:0]        ram_data_o,
  output logic               pause_dram_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [31:0]        sram_wdata_o,
  output logic               sram_data_oe_o,
  input  logic [31:0]        sram_rdata_i,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o,
  output logic [3:0]         sram_be_n_o
);

  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WRITE_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             addr_unused_s;

  // Word addressing drops the byte offset; upper bits are decoded by MEM.
  assign addr_unused_s = ^{mem_addr_i[31:SRAM_AW+2], mem_addr_i[1:0]};

  // Stall request: the DONE cycle is the one where the pipeline is let through.
  assign pause_dram_o = ram_en_i && (state_r != DRAM_DONE);

  // Access FSM, wait counter and all registered SRAM-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= DRAM_IDLE;
      cnt_r          <= CNT_ZERO;
      ram_data_o     <= 32'h0000_0000;
      sram_addr_o    <= {SRAM_AW{1'b0}};
      sram_wdata_o   <= 32'h0000_0000;
      sram_data_oe_o <= 1'b0;
      sram_ce_n_o    <= 1'b1;
      sram_oe_n_o    <= 1'b1;
      sram_we_n_o    <= 1'b1;
      sram_be_n_o    <= 4'hF;
    end else begin
      case (state_r)
        DRAM_IDLE: begin
          if (ram_en_i) begin
            sram_addr_o  <= mem_addr_i[SRAM_AW+1:2];
            sram_be_n_o  <= be_n_from_select(mem_select_i);
            sram_wdata_o <= store_data_i;
            if (!mem_write_en_i) begin
              state_r     <= DRAM_READ;
              cnt_r       <= RD_LOAD;
              sram_ce_n_o <= 1'b0;
              sram_oe_n_o <= 1'b0;
            end else if (mem_select_i != 4'b0000) begin
              state_r        <= DRAM_WRITE;
              cnt_r          <= WR_LOAD;
              sram_ce_n_o    <= 1'b0;
              sram_we_n_o    <= 1'b0;
              sram_data_oe_o <= 1'b1;
            end else begin
              // Misaligned store already flagged by MEM: complete with no strobe.
              state_r <= DRAM_DONE;
            end
          end else begin
            state_r <= DRAM_IDLE;
          end
        end
        DRAM_READ: begin
          if (cnt_r == CNT_ZERO) begin
            ram_data_o  <= sram_rdata_i;
            state_r     <= DRAM_DONE;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            sram_be_n_o <= 4'hF;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        DRAM_WRITE: begin
          if (cnt_r == CNT_ZERO) begin
            state_r     <= DRAM_WR_HOLD;
            sram_we_n_o <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        DRAM_WR_HOLD: begin
          // Address, lanes and data stay driven one cycle past WE_n rising.
          state_r        <= DRAM_DONE;
          sram_ce_n_o    <= 1'b1;
          sram_data_oe_o <= 1'b0;
          sram_be_n_o    <= 4'hF;
        end
        DRAM_DONE: begin
          state_r <= DRAM_IDLE;
        end
        default: begin
          state_r        <= DRAM_IDLE;
          cnt_r          <= CNT_ZERO;
          sram_data_oe_o <= 1'b0;
          sram_ce_n_o    <= 1'b1;
          sram_oe_n_o    <= 1'b1;
          sram_we_n_o    <= 1'b1;
          sram_be_n_o    <= 4'hF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Scoreboard bench for data_sram_ctrl: directed requests push expected
// responses; a negedge monitor pops and checks them at each DONE cycle.
module tb_data_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        ram_en_i;
  logic        mem_write_en_i;
  logic [3:0]  mem_select_i;
  logic [31:0] mem_addr_i;
  logic [31:0] store_data_i;
  logic [31:0] ram_data_o;
  logic        pause_dram_o;
  logic [19:0] sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic        sram_data_oe_o;
  logic [31:0] sram_rdata_i;
  logic        sram_ce_n_o;
  logic        sram_oe_n_o;
  logic        sram_we_n_o;
  logic [3:0]  sram_be_n_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] data;
    int          pause;
    int          ce;
    int          we;
    int          oe;
    int          doe;
    logic [3:0]  be;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0] mem [0:63];

  data_sram_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .ram_en_i       (ram_en_i),
    .mem_write_en_i (mem_write_en_i),
    .mem_select_i   (mem_select_i),
    .mem_addr_i     (mem_addr_i),
    .store_data_i   (store_data_i),
    .ram_data_o     (ram_data_o),
    .pause_dram_o   (pause_dram_o),
    .sram_addr_o    (sram_addr_o),
    .sram_wdata_o   (sram_wdata_o),
    .sram_data_oe_o (sram_data_oe_o),
    .sram_rdata_i   (sram_rdata_i),
    .sram_ce_n_o    (sram_ce_n_o),
    .sram_oe_n_o    (sram_oe_n_o),
    .sram_we_n_o    (sram_we_n_o),
    .sram_be_n_o    (sram_be_n_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Async SRAM model: read bus only driven while selected and output-enabled.
  assign sram_rdata_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[5:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (!sram_ce_n_o && !sram_we_n_o && sram_data_oe_o) begin
      for (int b = 0; b < 4; b++) begin
        if (!sram_be_n_o[b]) mem[sram_addr_o[5:0]][8*b +: 8] <= sram_wdata_o[8*b +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  int pcnt = 0, ccnt = 0, wcnt = 0, ocnt = 0, dcnt = 0;
  logic [3:0] seen_be = 4'hF;

  // Monitor: accumulate per-access strobe activity and score each DONE cycle.
  always @(negedge clk) begin
    if (rst) begin
      pcnt = 0; ccnt = 0; wcnt = 0; ocnt = 0; dcnt = 0;
    end else begin
      if (ram_en_i && pause_dram_o) pcnt++;
      if (!sram_ce_n_o) begin ccnt++; seen_be = sram_be_n_o; end
      if (!sram_we_n_o) wcnt++;
      if (!sram_oe_n_o) ocnt++;
      if (sram_data_oe_o) dcnt++;
      check("inv_we_oe", {31'd0, !sram_we_n_o && !sram_oe_n_o}, 32'd0);
      check("inv_doe_oe", {31'd0, sram_data_oe_o && !sram_oe_n_o}, 32'd0);
      check("inv_pause_en", {31'd0, pause_dram_o && !ram_en_i}, 32'd0);
      if (ram_en_i && !pause_dram_o) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("ram_data", ram_data_o, e.data);
          check("pause_cycles", pcnt, e.pause);
          check("ce_cycles", ccnt, e.ce);
          check("we_cycles", wcnt, e.we);
          check("oe_cycles", ocnt, e.oe);
          check("data_oe_cycles", dcnt, e.doe);
          if (e.ce != 0) check("be_n", {28'd0, seen_be}, {28'd0, e.be});
        end
        pcnt = 0; ccnt = 0; wcnt = 0; ocnt = 0; dcnt = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdata, input exp_t e);
    sb_q.push_back(e);
    ram_en_i       = 1'b1;
    mem_write_en_i = we;
    mem_select_i   = sel;
    mem_addr_i     = addr;
    store_data_i   = wdata;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (!pause_dram_o) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    ram_en_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [31:0] d, input int p, input int c, input int w,
                              input int o, input int de, input logic [3:0] be);
    exp_t e;
    e.data = d; e.pause = p; e.ce = c; e.we = w; e.oe = o; e.doe = de; e.be = be;
    return e;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
    mem[4]  = 32'hA1B2_C3D4;
    mem[8]  = 32'h1122_3344;
    mem[12] = 32'h0BAD_F00D;
    rst = 1'b1; ram_en_i = 1'b0; mem_write_en_i = 1'b0;
    mem_select_i = 4'h0; mem_addr_i = 32'h0; store_data_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ram_data", ram_data_o, 32'h0);
    check("rst_addr", {12'd0, sram_addr_o}, 32'h0);
    check("rst_wdata", sram_wdata_o, 32'h0);
    check("rst_strobes", {27'd0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_data_oe_o, pause_dram_o},
          {27'd0, 5'b11100});
    check("rst_be_n", {28'd0, sram_be_n_o}, 32'h0000_000F);
    @(posedge clk); #1;

    // Load word 4: pause 1,1,1,0 and OE low for two cycles.
    issue(1'b0, 4'b1111, 32'h8000_0010, 32'h0, mk(32'hA1B2_C3D4, 3, 2, 0, 2, 0, 4'b0000));
    wait_done(); idle_bus();

    // Byte store to lane 2 of word 8.
    issue(1'b1, 4'b0100, 32'h8000_0021, 32'h5A5A_5A5A, mk(32'hA1B2_C3D4, 4, 3, 2, 0, 3, 4'b1011));
    wait_done(); idle_bus();
    check("mem_byte_store", mem[8], 32'h115A_3344);

    // Store with no lanes selected: no strobe, memory untouched.
    issue(1'b1, 4'b0000, 32'h8000_0020, 32'hFFFF_FFFF, mk(32'hA1B2_C3D4, 1, 0, 0, 0, 0, 4'hF));
    wait_done(); idle_bus();
    check("mem_zero_sel", mem[8], 32'h115A_3344);

    // Full-word store then back-to-back loads of words 4 and 8.
    issue(1'b1, 4'b1111, 32'h8000_0030, 32'hCAFE_F00D, mk(32'hA1B2_C3D4, 4, 3, 2, 0, 3, 4'b0000));
    wait_done(); idle_bus();
    check("mem_word_store", mem[12], 32'hCAFE_F00D);

    issue(1'b0, 4'b1111, 32'h8000_0010, 32'h0, mk(32'hA1B2_C3D4, 3, 2, 0, 2, 0, 4'b0000));
    wait_done();
    issue(1'b0, 4'b1111, 32'h8000_0020, 32'h0, mk(32'h115A_3344, 3, 2, 0, 2, 0, 4'b0000));
    @(negedge clk);
    check("b2b_addr_idle", {12'd0, sram_addr_o}, 32'd4);
    @(negedge clk);
    check("b2b_addr_read", {12'd0, sram_addr_o}, 32'd8);
    wait_done();
    issue(1'b0, 4'b1111, 32'h8000_0030, 32'h0, mk(32'hCAFE_F00D, 3, 2, 0, 2, 0, 4'b0000));
    wait_done(); idle_bus();

    // Reset while WRITE has cnt=1: strobes drop on the reset edge.
    ram_en_i = 1'b1; mem_write_en_i = 1'b1; mem_select_i = 4'b0011;
    mem_addr_i = 32'h8000_0040; store_data_i = 32'h1234_5678;
    @(posedge clk); #1;
    check("pre_rst_we_n", {31'd0, sram_we_n_o}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_strobes", {28'd0, sram_we_n_o, sram_ce_n_o, sram_data_oe_o, sram_oe_n_o}, 32'b1101);
    check("abort_pause_en1", {31'd0, pause_dram_o}, 32'd1);
    ram_en_i = 1'b0;
    #1;
    check("abort_pause_en0", {31'd0, pause_dram_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_bus();

    // Controller must be fully usable after the abort.
    issue(1'b0, 4'b1111, 32'h8000_0010, 32'h0, mk(32'hA1B2_C3D4, 3, 2, 0, 2, 0, 4'b0000));
    wait_done(); idle_bus();
    repeat (2) @(posedge clk);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
